// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port round-robin arbiter sharing one memory between caches.
//            Define MEM_ARB_FIXED_PRI_EN for fixed priority (port 0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int WIDTH  = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rden0,
   input  logic              rden1,
   input  logic              wren0,
   input  logic              wren1,
   input  logic [AWIDTH-1:0] addr0,
   input  logic [AWIDTH-1:0] addr1,
   input  logic [WIDTH-1:0]  din0,
   input  logic [WIDTH-1:0]  din1,
   output logic [WIDTH-1:0]  q0,
   output logic [WIDTH-1:0]  q1,
   output logic              ack0,
   output logic              ack1,
   output logic              mrden,
   output logic [AWIDTH-1:0] mrdaddress,
   output logic              mwren,
   output logic [AWIDTH-1:0] mwraddress,
   output logic [WIDTH-1:0]  mdout,
   input  logic [WIDTH-1:0]  mq,
   output logic              busy,
   output logic              grant
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic               w_start;
   logic               r_grant;
   logic               r_is_write;
   logic [AWIDTH-1:0]  r_addr;
   logic [WIDTH-1:0]   r_data;

   logic               w_req0;
   logic               w_req1;
   logic               w_tie_winner;
   logic               w_winner;
   logic               w_winner_wr;
   logic [AWIDTH-1:0]  w_winner_addr;
   logic [WIDTH-1:0]   w_winner_data;

   assign w_req0 = rden0 | wren0;
   assign w_req1 = rden1 | wren1;

`ifdef MEM_ARB_FIXED_PRI_EN
   assign w_tie_winner = 1'b0;
`else
   logic r_last;

   // Tie goes to whichever port did not win most recently.
   assign w_tie_winner = ~r_last;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (w_start) begin
         r_last <= w_winner;
      end
   end
`endif

   assign w_winner      = !w_req0 ? 1'b1 : (w_req1 ? w_tie_winner : 1'b0);
   assign w_winner_wr   = w_winner ? wren1 : wren0;
   assign w_winner_addr = w_winner ? addr1 : addr0;
   assign w_winner_data = w_winner ? din1  : din0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_grant    <= 1'b0;
         r_is_write <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_start) begin
            r_grant    <= w_winner;
            r_is_write <= w_winner_wr;
            r_addr     <= w_winner_addr;
            r_data     <= w_winner_data;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req0 | w_req1) begin
               w_start      = 1'b1;
               w_next_state = S_ISSUE;
            end
         end
         S_ISSUE: w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   assign mrden      = (r_state == S_ISSUE) & ~r_is_write;
   assign mwren      = (r_state == S_ISSUE) &  r_is_write;
   assign mrdaddress = r_addr;
   assign mwraddress = r_addr;
   assign mdout      = r_data;
   assign busy       = (r_state != S_IDLE);
   assign grant      = r_grant;

   // Read data passes straight through from memory during the ack cycle only.
   assign ack0 = (r_state == S_RESP) & ~r_grant;
   assign ack1 = (r_state == S_RESP) &  r_grant;
   assign q0   = (ack0 & ~r_is_write) ? mq : '0;
   assign q1   = (ack1 & ~r_is_write) ? mq : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a small memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        rden0, rden1, wren0, wren1;
   logic [31:0] addr0, addr1, din0, din1;
   logic [31:0] q0, q1;
   logic        ack0, ack1;
   logic        mrden, mwren;
   logic [31:0] mrdaddress, mwraddress, mdout, mq;
   logic        busy, grant;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter #(.WIDTH(32), .AWIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .rden0(rden0), .rden1(rden1), .wren0(wren0), .wren1(wren1),
      .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
      .q0(q0), .q1(q1), .ack0(ack0), .ack1(ack1),
      .mrden(mrden), .mrdaddress(mrdaddress),
      .mwren(mwren), .mwraddress(mwraddress),
      .mdout(mdout), .mq(mq), .busy(busy), .grant(grant)
   );

   always #5 clock = ~clock;

   // Synchronous-read memory: mem[i] = i * 0x11 at start, not cleared by reset.
   logic [31:0] mem [16];
   logic        mem_loaded = 1'b0;
   always @(posedge clock) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'(i * 32'h11);
         mem_loaded <= 1'b1;
      end else begin
         if (mrden) mq <= mem[mrdaddress[3:0]];
         if (mwren) mem[mwraddress[3:0]] <= mdout;
      end
   end

   typedef struct {
      bit          port;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] din;
      bit          exp_wr;
      logic [31:0] exp_q;
   } vec_t;

   typedef struct {
      bit          port;
      logic [31:0] q;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_req();
      rden0 = 0; rden1 = 0; wren0 = 0; wren1 = 0;
      addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
   endtask

   task automatic set_req(input vec_t v);
      if (v.port) begin
         rden1 = v.rd; wren1 = v.wr; addr1 = v.addr; din1 = v.din;
      end else begin
         rden0 = v.rd; wren0 = v.wr; addr0 = v.addr; din0 = v.din;
      end
   endtask

   // Called at a falling edge while the arbiter is idle.
   task automatic run_vec(input vec_t v);
      exp_t e;
      set_req(v);
      sb.push_back('{port: v.port, q: v.exp_q});
      @(negedge clock);
      check("issue_mrden", 32'(mrden), 32'(!v.exp_wr));
      check("issue_mwren", 32'(mwren), 32'(v.exp_wr));
      check("issue_addr", v.exp_wr ? mwraddress : mrdaddress, v.addr);
      if (v.exp_wr) check("issue_mdout", mdout, v.din);
      check("issue_busy", 32'(busy), 32'd1);
      check("issue_grant", 32'(grant), 32'(v.port));
      check("issue_noack", 32'({ack1, ack0}), 32'd0);
      @(negedge clock);
      check("resp_men", 32'({mrden, mwren}), 32'd0);
      check("resp_ack", 32'({ack1, ack0}), v.port ? 32'd2 : 32'd1);
      e = sb.pop_front();
      check("resp_q", v.port ? q1 : q0, e.q);
      check("resp_other_q", v.port ? q0 : q1, 32'd0);
      clear_req();
      @(negedge clock);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int   waited;
      bit   got;
      bit   exp_port;
      bit   any_ack;
      exp_t e;

      vecs[0] = '{port: 0, rd: 1, wr: 0, addr: 32'd1, din: 32'h0,        exp_wr: 0, exp_q: 32'h00000011};
      vecs[1] = '{port: 1, rd: 0, wr: 1, addr: 32'd4, din: 32'hBADDBEEF, exp_wr: 1, exp_q: 32'h0};
      vecs[2] = '{port: 1, rd: 1, wr: 0, addr: 32'd4, din: 32'h0,        exp_wr: 0, exp_q: 32'hBADDBEEF};
      vecs[3] = '{port: 0, rd: 1, wr: 1, addr: 32'd2, din: 32'hAAAAAAAA, exp_wr: 1, exp_q: 32'h0};
      vecs[4] = '{port: 0, rd: 1, wr: 0, addr: 32'd2, din: 32'h0,        exp_wr: 0, exp_q: 32'hAAAAAAAA};
      vecs[5] = '{port: 1, rd: 1, wr: 0, addr: 32'd3, din: 32'h0,        exp_wr: 0, exp_q: 32'h00000033};

      reset = 1'b1;
      clear_req();
      repeat (3) @(negedge clock);
      check("rst_ack", 32'({ack1, ack0}), 32'd0);
      check("rst_q0", q0, 32'd0);
      check("rst_q1", q1, 32'd0);
      check("rst_men", 32'({mrden, mwren}), 32'd0);
      check("rst_rdaddr", mrdaddress, 32'd0);
      check("rst_wraddr", mwraddress, 32'd0);
      check("rst_mdout", mdout, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Both ports hold reads; expect alternating grants, acks every 3 cycles.
      rden0 = 1; addr0 = 32'd1;
      rden1 = 1; addr1 = 32'd3;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRI_EN
         exp_port = 1'b0;
`else
         exp_port = k[0];
`endif
         sb.push_back('{port: exp_port, q: exp_port ? 32'h33 : 32'h11});
      end
      for (int k = 0; k < 4; k++) begin
         got = 0;
         waited = 0;
         for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clock);
            if (ack0 | ack1) begin
               got = 1;
               waited = c;
            end
         end
         check("rr_ack_seen", 32'(got), 32'd1);
         check("rr_spacing", 32'(waited), (k == 0) ? 32'd2 : 32'd3);
         check("rr_single_ack", 32'(ack0 & ack1), 32'd0);
         e = sb.pop_front();
         check("rr_grant", 32'(ack1), 32'(e.port));
         check("rr_q", ack1 ? q1 : q0, e.q);
      end
      clear_req();
      @(negedge clock);

      // Reset during ISSUE of a read aborts it with no ack.
      rden0 = 1; addr0 = 32'd1;
      @(negedge clock);
      check("abort_issue_mrden", 32'(mrden), 32'd1);
      reset = 1'b1;
      #1;
      check("abort_mrden", 32'(mrden), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ack0", 32'(ack0), 32'd0);
      check("abort_addr", mrdaddress, 32'd0);
      clear_req();
      @(negedge clock);
      reset = 1'b0;
      any_ack = 0;
      repeat (5) begin
         @(negedge clock);
         any_ack |= (ack0 | ack1);
      end
      check("abort_no_ack", 32'(any_ack), 32'd0);

      run_vec(vecs[2]);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
